// File: rtl/gci_node_irq_pkg.sv
// ============================================================================
// gci_node_irq_pkg - shared encodings and widths for the GCI node IRQ requester (rev 1.0)
// ============================================================================
`default_nettype none

package gci_node_irq_pkg;

  localparam int L_PRIO_W = 8;
  localparam int L_OVF_W  = 8;

  localparam logic [1:0] L_PARAM_NIRQ_STT_IDLE    = 2'd0;
  localparam logic [1:0] L_PARAM_NIRQ_STT_REQ     = 2'd1;
  localparam logic [1:0] L_PARAM_NIRQ_STT_SERVICE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = L_PARAM_NIRQ_STT_IDLE,
    ST_REQ     = L_PARAM_NIRQ_STT_REQ,
    ST_SERVICE = L_PARAM_NIRQ_STT_SERVICE
  } nirq_state_e;

endpackage

`default_nettype wire

// File: rtl/gci_sat_counter.sv
// ============================================================================
// gci_sat_counter - saturating up-counter, synchronous clear has priority (rev 1.0)
// ============================================================================
`default_nettype none

module gci_sat_counter
  import gci_node_irq_pkg::*;
#(
  parameter int WIDTH = L_OVF_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/gci_node_irq_req.sv
// ============================================================================
// gci_node_irq_req - node-side IRQ requester: pending latch, request FSM, cause snapshot (rev 1.0)
// ============================================================================
`default_nettype none

module gci_node_irq_req
  import gci_node_irq_pkg::*;
#(
  parameter int P_N_SRC = 4
) (
  input  logic                iCLOCK,
  input  logic                inRESET,
  input  logic [P_N_SRC-1:0]  iEVENT,
  input  logic                iCFG_REQ,
  input  logic [P_N_SRC-1:0]  iCFG_MASK,
  input  logic [L_PRIO_W-1:0] iCFG_PRIORITY,
  output logic [L_PRIO_W-1:0] oNODEINFO_PRIORITY,
  input  logic                iIRQ_BUSY,
  output logic                oIRQ,
  input  logic                iIRQ_ACK,
  output logic                oCAUSE_VALID,
  output logic [P_N_SRC-1:0]  oCAUSE,
  input  logic                iCAUSE_CLR,
  output logic [P_N_SRC-1:0]  oPENDING,
  output logic [L_OVF_W-1:0]  oOVF_COUNT
);

  nirq_state_e         state, state_nxt;
  logic [P_N_SRC-1:0]  mask;
  logic [P_N_SRC-1:0]  pending;
  logic [P_N_SRC-1:0]  cause;
  logic [L_PRIO_W-1:0] prio;
  logic                irq;
  logic                cause_valid;

  logic [P_N_SRC-1:0]  enabled;
  logic [P_N_SRC-1:0]  ackclr;
  logic [P_N_SRC-1:0]  lost;
  logic                req_ok;
  logic                ack_fire;
  logic                clr_fire;

  assign enabled  = pending & mask;
  assign req_ok   = |enabled;
  assign ack_fire = (state == ST_REQ) && iIRQ_ACK;
  assign clr_fire = (state == ST_SERVICE) && iCAUSE_CLR;
  assign ackclr   = ack_fire ? enabled : '0;
  // An event landing on a bit being acknowledged re-arms it rather than being lost.
  assign lost     = iEVENT & pending & ~ackclr;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (req_ok && !iIRQ_BUSY) state_nxt = ST_REQ;
      end
      ST_REQ: begin
        if (iIRQ_ACK)     state_nxt = ST_SERVICE;
        else if (!req_ok) state_nxt = ST_IDLE;
      end
      ST_SERVICE: begin
        if (iCAUSE_CLR) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state       <= ST_IDLE;
      irq         <= 1'b0;
      cause_valid <= 1'b0;
      pending     <= '0;
      cause       <= '0;
      mask        <= '0;
      prio        <= '0;
    end else begin
      state       <= state_nxt;
      irq         <= (state_nxt == ST_REQ);
      cause_valid <= (state_nxt == ST_SERVICE);
      pending     <= (pending & ~ackclr) | iEVENT;
      // Snapshot sees the mask of this cycle, so a same-cycle config write does not affect it.
      if (ack_fire) begin
        cause <= enabled;
      end else if (clr_fire) begin
        cause <= '0;
      end
      if (iCFG_REQ) begin
        mask <= iCFG_MASK;
        prio <= iCFG_PRIORITY;
      end
    end
  end

  gci_sat_counter #(
    .WIDTH (L_OVF_W)
  ) u_ovf_cnt (
    .clk   (iCLOCK),
    .rst_n (inRESET),
    .inc   (|lost),
    .clr   (iCFG_REQ),
    .count (oOVF_COUNT)
  );

  assign oIRQ               = irq;
  assign oCAUSE_VALID       = cause_valid;
  assign oCAUSE             = cause;
  assign oPENDING           = pending;
  assign oNODEINFO_PRIORITY = prio;

endmodule

`default_nettype wire

// File: tb/tb_gci_node_irq_req.sv
// ============================================================================
// tb_gci_node_irq_req - directed vector table plus multi-cycle sequences (rev 1.0)
// ============================================================================
`default_nettype none

module tb_gci_node_irq_req;

  logic       clk;
  logic       rst_n;
  logic [3:0] ev;
  logic       cfg_req;
  logic [3:0] cfg_mask;
  logic [7:0] cfg_pri;
  logic [7:0] pri_o;
  logic       busy;
  logic       irq;
  logic       ack;
  logic       cause_valid;
  logic [3:0] cause;
  logic       cause_clr;
  logic [3:0] pending;
  logic [7:0] ovf;

  int checks;
  int failures;

  gci_node_irq_req #(.P_N_SRC(4)) dut (
    .iCLOCK             (clk),
    .inRESET            (rst_n),
    .iEVENT             (ev),
    .iCFG_REQ           (cfg_req),
    .iCFG_MASK          (cfg_mask),
    .iCFG_PRIORITY      (cfg_pri),
    .oNODEINFO_PRIORITY (pri_o),
    .iIRQ_BUSY          (busy),
    .oIRQ               (irq),
    .iIRQ_ACK           (ack),
    .oCAUSE_VALID       (cause_valid),
    .oCAUSE             (cause),
    .iCAUSE_CLR         (cause_clr),
    .oPENDING           (pending),
    .oOVF_COUNT         (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] ev;
    logic       cfg;
    logic [3:0] mask;
    logic [7:0] pri;
    logic       busy;
    logic       ack;
    logic       clr;
    logic       e_irq;
    logic       e_cv;
    logic [3:0] e_cause;
    logic [3:0] e_pend;
    logic [7:0] e_ovf;
    logic [7:0] e_pri;
  } vec_t;

  localparam int N_VEC = 44;
  vec_t vt [N_VEC];

  function automatic vec_t mk(logic [3:0] e, logic c, logic [3:0] m, logic [7:0] p,
                              logic b, logic a, logic cl, logic xi, logic xv,
                              logic [3:0] xc, logic [3:0] xp, logic [7:0] xo, logic [7:0] xr);
    vec_t v;
    v.ev = e; v.cfg = c; v.mask = m; v.pri = p; v.busy = b; v.ack = a; v.clr = cl;
    v.e_irq = xi; v.e_cv = xv; v.e_cause = xc; v.e_pend = xp; v.e_ovf = xo; v.e_pri = xr;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s[%0d] got=0x%0h exp=0x%0h", name, idx, got, exp);
    end
  endtask

  task automatic chk_all(input int idx, input logic xi, input logic xv, input logic [3:0] xc,
                         input logic [3:0] xp, input logic [7:0] xo, input logic [7:0] xr);
    chk("irq", idx, int'(irq), int'(xi));
    chk("cause_valid", idx, int'(cause_valid), int'(xv));
    chk("cause", idx, int'(cause), int'(xc));
    chk("pending", idx, int'(pending), int'(xp));
    chk("ovf", idx, int'(ovf), int'(xo));
    chk("priority", idx, int'(pri_o), int'(xr));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ev = 4'h0; cfg_req = 1'b0; cfg_mask = 4'h0; cfg_pri = 8'h00;
    busy = 1'b0; ack = 1'b0; cause_clr = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    //            ev  cfg mask pri    bsy ack clr | irq cv cause pend ovf    pri
    vt[0]  = mk(4'h0, 1, 4'h5, 8'h30, 0, 0, 0,   0, 0, 4'h0, 4'h0, 8'd0, 8'h30);
    vt[1]  = mk(4'h1, 0, 4'h0, 8'h00, 0, 0, 0,   0, 0, 4'h0, 4'h1, 8'd0, 8'h30);
    vt[2]  = mk(4'h0, 0, 4'h0, 8'h00, 0, 0, 0,   1, 0, 4'h0, 4'h1, 8'd0, 8'h30);
    vt[3]  = mk(4'h0, 0, 4'h0, 8'h00, 0, 1, 0,   0, 1, 4'h1, 4'h0, 8'd0, 8'h30);
    vt[4]  = mk(4'h0, 0, 4'h0, 8'h00, 0, 0, 1,   0, 0, 4'h0, 4'h0, 8'd0, 8'h30);
    vt[5]  = mk(4'h2, 0, 4'h0, 8'h00, 0, 0, 0,   0, 0, 4'h0, 4'h2, 8'd0, 8'h30);
    vt[6]  = mk(4'h0, 0, 4'h0, 8'h00, 0, 0, 0,   0, 0, 4'h0, 4'h2, 8'd0, 8'h30);
    vt[7]  = mk(4'h0, 1, 4'h2, 8'h30, 0, 0, 0,   0, 0, 4'h0, 4'h2, 8'd0, 8'h30);
    vt[8]  = mk(4'h0, 0, 4'h0, 8'h00, 0, 0, 0,   1, 0, 4'h0, 4'h2, 8'd0, 8'h30);
    vt[9]  = mk(4'h0, 0, 4'h0, 8'h00, 0, 1, 0,   0, 1, 4'h2, 4'h0, 8'd0, 8'h30);
    vt[10] = mk(4'h0, 0, 4'h0, 8'h00, 0, 0, 1,   0, 0, 4'h0, 4'h0, 8'd0, 8'h30);
    vt[11] = mk(4'h0, 1, 4'h3, 8'h30, 0, 0, 0,   0, 0, 4'h0, 4'h0, 8'd0, 8'h30);
    vt[12] = mk(4'h1, 0, 4'h0, 8'h00, 0, 0, 0,   0, 0, 4'h0, 4'h1, 8'd0, 8'h30);
    vt[13] = mk(4'h0, 0, 4'h0, 8'h00, 0, 0, 0,   1, 0, 4'h0, 4'h1, 8'd0, 8'h30);
    vt[14] = mk(4'h0, 1, 4'h0, 8'h30, 0, 0, 0,   1, 0, 4'h0, 4'h1, 8'd0, 8'h30);
    vt[15] = mk(4'h0, 0, 4'h0, 8'h00, 0, 0, 0,   0, 0, 4'h0, 4'h1, 8'd0, 8'h30);
    vt[16] = mk(4'h0, 0, 4'h0, 8'h00, 0, 0, 0,   0, 0, 4'h0, 4'h1, 8'd0, 8'h30);
    vt[17] = mk(4'h0, 1, 4'h1, 8'h30, 1, 0, 0,   0, 0, 4'h0, 4'h1, 8'd0, 8'h30);
    vt[18] = mk(4'h0, 0, 4'h0, 8'h00, 1, 0, 0,   0, 0, 4'h0, 4'h1, 8'd0, 8'h30);
    vt[19] = mk(4'h0, 0, 4'h0, 8'h00, 1, 0, 0,   0, 0, 4'h0, 4'h1, 8'd0, 8'h30);
    vt[20] = mk(4'h0, 0, 4'h0, 8'h00, 0, 0, 0,   1, 0, 4'h0, 4'h1, 8'd0, 8'h30);
    vt[21] = mk(4'h0, 0, 4'h0, 8'h00, 1, 0, 0,   1, 0, 4'h0, 4'h1, 8'd0, 8'h30);
    vt[22] = mk(4'h0, 0, 4'h0, 8'h00, 0, 1, 0,   0, 1, 4'h1, 4'h0, 8'd0, 8'h30);
    vt[23] = mk(4'h0, 0, 4'h0, 8'h00, 0, 1, 0,   0, 1, 4'h1, 4'h0, 8'd0, 8'h30);
    vt[24] = mk(4'h0, 0, 4'h0, 8'h00, 0, 0, 1,   0, 0, 4'h0, 4'h0, 8'd0, 8'h30);
    vt[25] = mk(4'h0, 0, 4'h0, 8'h00, 0, 1, 0,   0, 0, 4'h0, 4'h0, 8'd0, 8'h30);
    vt[26] = mk(4'h1, 0, 4'h0, 8'h00, 0, 0, 0,   0, 0, 4'h0, 4'h1, 8'd0, 8'h30);
    vt[27] = mk(4'h0, 0, 4'h0, 8'h00, 0, 0, 0,   1, 0, 4'h0, 4'h1, 8'd0, 8'h30);
    vt[28] = mk(4'h0, 0, 4'h0, 8'h00, 0, 1, 0,   0, 1, 4'h1, 4'h0, 8'd0, 8'h30);
    vt[29] = mk(4'h1, 0, 4'h0, 8'h00, 0, 0, 0,   0, 1, 4'h1, 4'h1, 8'd0, 8'h30);
    vt[30] = mk(4'h1, 0, 4'h0, 8'h00, 0, 0, 0,   0, 1, 4'h1, 4'h1, 8'd1, 8'h30);
    vt[31] = mk(4'h1, 0, 4'h0, 8'h00, 0, 0, 0,   0, 1, 4'h1, 4'h1, 8'd2, 8'h30);
    vt[32] = mk(4'h0, 0, 4'h0, 8'h00, 0, 0, 1,   0, 0, 4'h0, 4'h1, 8'd2, 8'h30);
    vt[33] = mk(4'h0, 0, 4'h0, 8'h00, 0, 0, 0,   1, 0, 4'h0, 4'h1, 8'd2, 8'h30);
    vt[34] = mk(4'h1, 0, 4'h0, 8'h00, 0, 1, 0,   0, 1, 4'h1, 4'h1, 8'd2, 8'h30);
    vt[35] = mk(4'h0, 0, 4'h0, 8'h00, 0, 0, 1,   0, 0, 4'h0, 4'h1, 8'd2, 8'h30);
    vt[36] = mk(4'h0, 0, 4'h0, 8'h00, 0, 0, 0,   1, 0, 4'h0, 4'h1, 8'd2, 8'h30);
    vt[37] = mk(4'h0, 0, 4'h0, 8'h00, 0, 0, 1,   1, 0, 4'h0, 4'h1, 8'd2, 8'h30);
    vt[38] = mk(4'h0, 1, 4'h0, 8'h5A, 0, 1, 0,   0, 1, 4'h1, 4'h0, 8'd0, 8'h5A);
    vt[39] = mk(4'h0, 0, 4'h0, 8'h00, 0, 0, 1,   0, 0, 4'h0, 4'h0, 8'd0, 8'h5A);
    vt[40] = mk(4'hF, 0, 4'h0, 8'h00, 0, 0, 0,   0, 0, 4'h0, 4'hF, 8'd0, 8'h5A);
    vt[41] = mk(4'h0, 0, 4'h0, 8'h00, 0, 0, 0,   0, 0, 4'h0, 4'hF, 8'd0, 8'h5A);
    vt[42] = mk(4'h1, 0, 4'h0, 8'h00, 0, 0, 0,   0, 0, 4'h0, 4'hF, 8'd1, 8'h5A);
    vt[43] = mk(4'h2, 1, 4'h0, 8'h5A, 0, 0, 0,   0, 0, 4'h0, 4'hF, 8'd0, 8'h5A);

    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    chk_all(-1, 1'b0, 1'b0, 4'h0, 4'h0, 8'd0, 8'h00);
    #2 rst_n = 1'b1;

    for (int i = 0; i < N_VEC; i++) begin
      ev = vt[i].ev; cfg_req = vt[i].cfg; cfg_mask = vt[i].mask; cfg_pri = vt[i].pri;
      busy = vt[i].busy; ack = vt[i].ack; cause_clr = vt[i].clr;
      tick();
      chk_all(i, vt[i].e_irq, vt[i].e_cv, vt[i].e_cause, vt[i].e_pend, vt[i].e_ovf, vt[i].e_pri);
    end

    // Saturation: every cycle loses an event on already-pending bit 0.
    idle_inputs();
    ev = 4'h1;
    for (int i = 0; i < 254; i++) tick();
    chk("ovf_254", 100, int'(ovf), 254);
    for (int i = 0; i < 46; i++) tick();
    chk("ovf_sat", 101, int'(ovf), 255);
    ev = 4'h0; cfg_req = 1'b1; cfg_mask = 4'h0; cfg_pri = 8'h5A;
    tick();
    chk("ovf_clr", 102, int'(ovf), 0);

    // Reset in the middle of a serviced handshake.
    cfg_mask = 4'h1;
    tick();
    idle_inputs();
    tick();
    chk("rst_seq_irq", 103, int'(irq), 1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk_all(104, 1'b0, 1'b1, 4'h1, 4'hE, 8'd0, 8'h5A);
    #3 rst_n = 1'b0;
    #1;
    chk_all(105, 1'b0, 1'b0, 4'h0, 4'h0, 8'd0, 8'h00);
    #2 rst_n = 1'b1;
    tick();
    chk_all(106, 1'b0, 1'b0, 4'h0, 4'h0, 8'd0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/gci_node_irq_req.md
# gci_node_irq_req

Node-side interrupt requester for the GCI bus, and the counterpart of the hub's IRQ arbiter. It latches local event pulses into per-source pending bits and raises a single IRQ line toward the hub, holding it until the hub acknowledges. On acknowledge it snapshots the enabled pending sources into a cause register, which the node's register interface reads and clears. It also publishes the node's 8-bit IRQ priority and counts events lost to already-pending sources.

## Interface
- P_N_SRC, default 4: number of local event sources, legal range 1..8.
- iCLOCK  in  1  system clock; all state changes on its rising edge.
- inRESET  in  1  asynchronous, active-low reset.
- iEVENT  in  P_N_SRC  per-source event; each cycle it is high counts as one event.
- iCFG_REQ  in  1  configuration write strobe.
- iCFG_MASK  in  P_N_SRC  enable mask written on iCFG_REQ; 1 = source may request.
- iCFG_PRIORITY  in  8  priority written on iCFG_REQ.
- oNODEINFO_PRIORITY  out  8  registered priority, routed to the hub's priority input.
- iIRQ_BUSY  in  1  hub busy, driven from the hub's node-IRQ busy output; blocks new requests.
- oIRQ  out  1  interrupt request to the hub.
- iIRQ_ACK  in  1  hub acknowledge for this node; may be combinational in the hub.
- oCAUSE_VALID  out  1  cause register holds an unserviced snapshot.
- oCAUSE  out  P_N_SRC  snapshot of enabled pending sources taken at acknowledge.
- iCAUSE_CLR  in  1  software has consumed the cause.
- oPENDING  out  P_N_SRC  raw pending bits, unmasked.
- oOVF_COUNT  out  8  saturating count of cycles with at least one lost event.

## Operation
- Reset values: oIRQ=0, oCAUSE_VALID=0, oCAUSE=0, oPENDING=0, oOVF_COUNT=0, oNODEINFO_PRIORITY=8'h00, mask=0.
- Pending update: pending <= (pending & ~ackclr) | iEVENT.
  - ackclr = pending & mask in the acknowledge cycle; otherwise 0.
  - Pending bits latch regardless of mask; the mask gates requests only.
- Overflow: if any bit has iEVENT=1 and pending=1 and is not cleared by ackclr in that cycle, oOVF_COUNT increments by 1. It saturates at 8'hFF.
- Config write (iCFG_REQ=1):
  - mask and priority update on the next edge.
  - oOVF_COUNT clears to 0; the clear wins over an increment in the same cycle.
- Let req_ok = |(pending & mask), using registered values.
- States:
  - IDLE: if req_ok and !iIRQ_BUSY, go to REQ.
  - REQ: oIRQ=1.
    - If iIRQ_ACK: oCAUSE <= pending & mask, apply ackclr, go to SERVICE.
    - Else if !req_ok (mask write removed every enabled source): withdraw and go to IDLE.
    - iIRQ_BUSY does not drop oIRQ once in REQ.
  - SERVICE: oCAUSE_VALID=1; new events keep accumulating in pending.
    - On iCAUSE_CLR: oCAUSE <= 0, go to IDLE.
- Outside SERVICE: iCAUSE_CLR is ignored.
- Outside REQ: iIRQ_ACK is ignored and causes no snapshot or clear.
- Simultaneous event and acknowledge on the same bit: the bit is cleared by ackclr and re-set by iEVENT. It stays pending for the next request and is not counted as an overflow.
- Simultaneous config write and acknowledge: the snapshot uses the old mask.

## Timing
- oIRQ, oCAUSE_VALID, oCAUSE, oPENDING, oOVF_COUNT and oNODEINFO_PRIORITY are registered; none depends combinationally on an input.
- Event to request: iEVENT high in cycle t → pending in t+1 → oIRQ high in t+2, provided the source is masked in and the hub is not busy in t+1.
- Acknowledge: iIRQ_ACK in cycle k (state REQ) → oIRQ low and oCAUSE_VALID high in k+1.
- Clear to next request: iCAUSE_CLR in cycle c → IDLE in c+1. oIRQ can re-assert at c+2 at the earliest.
- Asserting inRESET mid-handshake returns the block to IDLE immediately (asynchronously); in-flight cause and pending state are discarded.

## Structure
- Shared package gci_node_irq_pkg holds:
  - State encodings L_PARAM_NIRQ_STT_IDLE=2'd0, _REQ=2'd1, _SERVICE=2'd2.
  - Priority width 8 and overflow counter width 8.
- One sub-module, gci_sat_counter: an 8-bit saturating counter with inc and clr inputs, where clr has priority. It is instantiated for oOVF_COUNT.
- Pending logic, mask/priority registers and the FSM stay in the top module.

## Test plan
- Reset, then write mask=4'b0101, priority=8'h30; pulse iEVENT=4'b0001 → oNODEINFO_PRIORITY=8'h30 next cycle, oIRQ=1 two cycles after the pulse; ACK → oCAUSE=4'b0001, oCAUSE_VALID=1, oPENDING=0.
- Pulse iEVENT=4'b0010 with mask=4'b0101 → oPENDING=4'b0010, oIRQ stays 0; then write mask=4'b0010 → oIRQ=1 two cycles after the write.
- In REQ with pending=4'b0001, write mask=0 → oIRQ drops next cycle, state returns to IDLE, oPENDING=4'b0001 is kept.
- Hold iIRQ_BUSY=1 with an enabled source pending → oIRQ stays 0; release busy → oIRQ=1 one cycle later.
- In SERVICE, pulse iEVENT=4'b0001 three times with bit 0 pending → oOVF_COUNT=2; after 300 such cycles → 8'hFF; config write → 0.
- Assert iEVENT[0] in the same cycle as ACK → oCAUSE[0]=1 and oPENDING[0]=1 after; iCAUSE_CLR → oIRQ=1 again two cycles later, oOVF_COUNT unchanged.
